// File: rtl/axi_burst_ram_if.sv
// AXI4 bus bundle between a router slave port (master side) and the burst RAM (slave side).
// Carries the AW, W, B, AR and R channels; lengths, sizes and bursts follow AXI4 encodings.
interface axi_burst_ram_if #(
    parameter int unsigned ID_W_WIDTH = 4,
    parameter int unsigned ID_R_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

    logic [ID_W_WIDTH-1:0] awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [NB-1:0]         wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_W_WIDTH-1:0] bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_R_WIDTH-1:0] arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_R_WIDTH-1:0] rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_burst_ram.sv
// AXI4 burst RAM endpoint: independent read and write engines over a dual-port word array,
// FIXED/INCR/WRAP bursts, SLVERR/DECERR checking and a 2-entry read skid buffer.
module axi_burst_ram #(
    parameter int unsigned ID_W_WIDTH = 4,
    parameter int unsigned ID_R_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    axi_burst_ram_if.slave  in_axi
);
    localparam int unsigned NB     = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned FULL   = $clog2(NB);
    localparam int unsigned WORD_W = ADDR_WIDTH - FULL;
    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [1:0] {RIdle, RAddr, RDrain} r_state_e;

    function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] word,
                                                    input logic [7:0]        len,
                                                    input logic [1:0]        burst);
        logic [WORD_W-1:0] mask;
        mask = WORD_W'(len);
        case (burst)
            BURST_FIXED: next_word = word;
            // len+1 is a power of two here, so len doubles as the in-window offset mask
            BURST_WRAP:  next_word = (word & ~mask) | ((word + 1'b1) & mask);
            default:     next_word = word + 1'b1;
        endcase
    endfunction

    // Whole-burst errors: wrong beat size, reserved burst type, or WRAP with a bad length
    function automatic logic burst_bad(input logic [2:0] size,
                                       input logic [7:0] len,
                                       input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_bad = (size != 3'(FULL)) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

    function automatic logic in_range(input logic [WORD_W-1:0] word);
        in_range = 32'(word) < MEM_DEPTH;
    endfunction

    function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
        worst = (a > b) ? a : b;
    endfunction

    // Holds both engines off until the first clock edge after reset
    logic alive_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- write engine
    w_state_e              w_state_q, w_state_d;
    logic [ID_W_WIDTH-1:0] w_id_q, w_id_d;
    logic [WORD_W-1:0]     w_word_q, w_word_d;
    logic [7:0]            w_len_q, w_len_d;
    logic [7:0]            w_cnt_q, w_cnt_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic                  w_bad_q, w_bad_d;
    logic [1:0]            w_resp_q, w_resp_d;
    logic [1:0]            w_beat_resp;
    logic                  aw_ready, w_ready, mem_we;

    always_comb begin
        w_state_d   = w_state_q;
        w_id_d      = w_id_q;
        w_word_d    = w_word_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_burst_d   = w_burst_q;
        w_bad_d     = w_bad_q;
        w_resp_d    = w_resp_q;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        mem_we      = 1'b0;
        w_beat_resp = w_bad_q ? RESP_SLVERR : (in_range(w_word_q) ? RESP_OKAY : RESP_DECERR);

        unique case (w_state_q)
            WIdle: begin
                aw_ready = alive_q;
                if (alive_q && in_axi.awvalid) begin
                    w_id_d    = in_axi.awid;
                    w_word_d  = in_axi.awaddr[ADDR_WIDTH-1:FULL];
                    w_len_d   = in_axi.awlen;
                    w_burst_d = in_axi.awburst;
                    w_bad_d   = burst_bad(in_axi.awsize, in_axi.awlen, in_axi.awburst);
                    w_cnt_d   = 8'd0;
                    w_resp_d  = RESP_OKAY;
                    w_state_d = WData;
                end
            end
            WData: begin
                w_ready = 1'b1;
                if (in_axi.wvalid) begin
                    mem_we   = (w_beat_resp == RESP_OKAY);
                    w_resp_d = worst(w_resp_q, w_beat_resp);
                    // Termination follows the beat count; wlast only flags a protocol error
                    if (in_axi.wlast != (w_cnt_q == w_len_q)) begin
                        w_resp_d = worst(w_resp_d, RESP_SLVERR);
                    end
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = WResp;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_word_d = next_word(w_word_q, w_len_q, w_burst_q);
                    end
                end
            end
            WResp: begin
                if (in_axi.bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_word_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_bad_q   <= 1'b0;
            w_resp_q  <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_word_q  <= w_word_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_bad_q   <= w_bad_d;
            w_resp_q  <= w_resp_d;
        end
    end

    assign in_axi.awready = aw_ready;
    assign in_axi.wready  = w_ready;
    assign in_axi.bvalid  = (w_state_q == WResp);
    assign in_axi.bid     = w_id_q;
    assign in_axi.bresp   = w_resp_q;

    // ---------------------------------------------------------------- array
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [IDX_W-1:0]      mem_widx;

    assign mem_widx = w_word_q[IDX_W-1:0];

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (in_axi.wstrb[b]) begin
                    mem[mem_widx][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                        in_axi.wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // ---------------------------------------------------------------- read engine
    r_state_e              r_state_q, r_state_d;
    logic [ID_R_WIDTH-1:0] r_id_q, r_id_d;
    logic [WORD_W-1:0]     r_word_q, r_word_d;
    logic [7:0]            r_len_q, r_len_d;
    logic [7:0]            r_cnt_q, r_cnt_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic                  r_bad_q, r_bad_d;
    logic [1:0]            r_beat_resp;
    logic                  ar_ready, r_issue, r_pop;

    logic [ID_R_WIDTH-1:0] f_id   [2];
    logic [DATA_WIDTH-1:0] f_data [2];
    logic [1:0]            f_resp [2];
    logic                  f_last [2];
    logic                  f_wptr_q, f_rptr_q;
    logic [1:0]            f_cnt_q;

    assign r_pop       = (f_cnt_q != 2'd0) && in_axi.rready;
    assign r_beat_resp = r_bad_q ? RESP_SLVERR : (in_range(r_word_q) ? RESP_OKAY : RESP_DECERR);

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_word_d  = r_word_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        r_bad_d   = r_bad_q;
        ar_ready  = 1'b0;
        r_issue   = 1'b0;

        unique case (r_state_q)
            RIdle: begin
                ar_ready = alive_q;
                if (alive_q && in_axi.arvalid) begin
                    r_id_d    = in_axi.arid;
                    r_word_d  = in_axi.araddr[ADDR_WIDTH-1:FULL];
                    r_len_d   = in_axi.arlen;
                    r_burst_d = in_axi.arburst;
                    r_bad_d   = burst_bad(in_axi.arsize, in_axi.arlen, in_axi.arburst);
                    r_cnt_d   = 8'd0;
                    r_state_d = RAddr;
                end
            end
            RAddr: begin
                // A slot freed by this cycle's pop can be refilled in the same cycle
                if ((f_cnt_q != 2'd2) || r_pop) begin
                    r_issue = 1'b1;
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = RDrain;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_word_d = next_word(r_word_q, r_len_q, r_burst_q);
                    end
                end
            end
            RDrain: begin
                if (r_pop && f_last[f_rptr_q]) begin
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_word_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            r_bad_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_word_q  <= r_word_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            r_bad_q   <= r_bad_d;
        end
    end

    // Skid buffer: the array read lands straight in a slot, so a same-cycle write is not seen
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < 2; e++) begin
                f_id[e]   <= '0;
                f_data[e] <= '0;
                f_resp[e] <= RESP_OKAY;
                f_last[e] <= 1'b0;
            end
            f_wptr_q <= 1'b0;
            f_rptr_q <= 1'b0;
            f_cnt_q  <= 2'd0;
        end else begin
            if (r_issue) begin
                f_id[f_wptr_q]   <= r_id_q;
                f_data[f_wptr_q] <= (r_beat_resp == RESP_OKAY) ? mem[r_word_q[IDX_W-1:0]] : '0;
                f_resp[f_wptr_q] <= r_beat_resp;
                f_last[f_wptr_q] <= (r_cnt_q == r_len_q);
                f_wptr_q         <= ~f_wptr_q;
            end
            if (r_pop) begin
                f_rptr_q <= ~f_rptr_q;
            end
            f_cnt_q <= f_cnt_q + 2'(r_issue) - 2'(r_pop);
        end
    end

    assign in_axi.arready = ar_ready;
    assign in_axi.rvalid  = (f_cnt_q != 2'd0);
    assign in_axi.rid     = f_id[f_rptr_q];
    assign in_axi.rdata   = f_data[f_rptr_q];
    assign in_axi.rresp   = f_resp[f_rptr_q];
    assign in_axi.rlast   = f_last[f_rptr_q];

endmodule
